vrf_sequencer: RTL and testbench
================================

# vrf_sequencer

Command sequencer in front of the vector register file (32 × 128-bit registers, two read ports, one write port, vl/vtype state). Accepts vsetvl and vector-op commands over a valid/ready handshake. vsetvl computes and writes vl/vtype. Vector ops step through the LMUL register group one register per cycle: it drives read addresses, tracks execute-unit latency and drives the delayed write address and enable. Register data flows directly between the register file and the execute unit; this block handles control only.

## Interface
- AVL_W, 16, width of requested application vector length
- EXE_LAT, 1, execute-unit latency in cycles from read address to write-back (legal 1..4)

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept (high only in IDLE)
- cmd_op  in  1  0 = VOP, 1 = VSETVL
- cmd_vd, cmd_vs1, cmd_vs2  in  5 each  group base registers
- cmd_avl  in  AVL_W  requested vector length (VSETVL)
- cmd_vtype  in  7  [2:0] vlmul (0..3 → 1,2,4,8), [5:3] vsew (0..3 → 8..64), [6] vta
- vl  in  9  current vl from register file
- vtype  in  7  current vtype from register file
- rf_raA, rf_raB  out  5  read addresses (vs1+i, vs2+i)
- rf_wa  out  5  write address
- rf_wen  out  1  write enable
- rf_vl_in  out  9, rf_vl_wen  out  1  vl update
- rf_vtype_in  out  7, rf_vtype_wen  out  1  vtype update
- exe_valid  out  1  read addresses this cycle are a valid element group
- done  out  1  one-cycle pulse on command completion
- err  out  1  one-cycle pulse coincident with done on illegal command

## Operation
- FSM: IDLE, CFG, RUN, DRAIN.
- IDLE → CFG on accepted VSETVL. → RUN on accepted VOP with N>0. → IDLE with done the next cycle when N=0 or the VOP is illegal; no writes occur.
- VSETVL (CFG, one cycle):
  - Legal vtype (vlmul ≤ 3, vsew ≤ 3): VLMAX = (16 << vlmul) >> vsew. Write vl = min(avl, VLMAX) and vtype = cmd_vtype.
  - Illegal vtype: write vl = 0, vtype = 7'h00, pulse err.
  - done pulses in CFG, then return to IDLE.
- VOP: vl and vtype are sampled at acceptance.
  - N = ceil(vl / (16 >> vsew)), so N ≤ LMUL.
  - RUN issues i = 0..N-1 on consecutive cycles: rf_raA = vs1+i, rf_raB = vs2+i, exe_valid = 1.
  - A shift pipe of EXE_LAT stages carries {valid, vd+i}. Its output drives rf_wa/rf_wen.
  - After the last issue go to DRAIN. Leave DRAIN when the pipe empties; done pulses with the last rf_wen.
- Address arithmetic is 5-bit and wraps modulo 32.
- While not in IDLE, cmd_valid is ignored.

## Timing
- Reset values: all outputs 0, state IDLE. cmd_ready is 1 from the first clock after rst deasserts.
- Accept at cycle 0 (cmd_valid & cmd_ready).
  - VSETVL: write strobes and done at cycle 1; cmd_ready high at cycle 2.
  - VOP: reads at cycles 1..N; rf_wen at cycles 1+EXE_LAT..N+EXE_LAT; done at cycle N+EXE_LAT; cmd_ready high at cycle N+EXE_LAT+1.
- A VOP accepted at cycle 2 after a VSETVL sees the new vl/vtype.
- Reset asserted mid-operation aborts immediately: pipe cleared, no further rf_wen, no done.

## Configuration
- VRF_SEQ_ALIGN_CHECK_EN
  - Defined: a VOP whose vd, vs1 or vs2 is not a multiple of LMUL is illegal. It produces done+err at cycle 1 with no reads or writes.
  - Undefined: no check; addresses wrap modulo 32.

## Structure
- Shared package vrf_pkg holds:
  - VLEN = 128, NREG = 32, VL_W = 9, VTYPE_W = 7
  - vtype field offsets
  - the state enum
  - a VLMAX function
- One sub-module, vrf_seq_wpipe: the EXE_LAT-deep valid/address delay pipe with synchronous clear.

## Test plan
- VSETVL avl=100, vtype={vta0, sew8, lmul4} → cycle 1: rf_vl_in=64, rf_vl_wen=1, rf_vtype_wen=1, done=1.
- vl=64, sew8, lmul4, VOP vd=8, vs1=16, vs2=24, EXE_LAT=1:
  - reads (16,24)…(19,27) at cycles 1–4
  - writes wa 8..11 at cycles 2–5
  - done at cycle 5
- vl=20, sew32 (4 elements per register) → N=5 would exceed LMUL. Instead set lmul8 and vl=20 → 5 writes vd..vd+4; no write to vd+5.
- VSETVL vtype vsew=5 → vl=0, vtype=0, err+done at cycle 1. A following VOP → done at cycle 1, no rf_wen.
- With VRF_SEQ_ALIGN_CHECK_EN defined, lmul2, vd=3 → err+done at cycle 1, no writes. With it undefined, vd=31, N=2 → writes 31 then 0.
- rst low at cycle 2 of a 4-register VOP → outputs 0 immediately; no rf_wen or done afterwards; cmd_ready=1 after release.

Source files
------------

// File: rtl/vrf_pkg.sv
// -----------------------------------------------------------------------------
// vrf_pkg
// Shared definitions for the vector register file command sequencer:
// register file geometry, vtype field layout, sequencer state encoding and
// the vector-length helper functions used by the sequencer.
// -----------------------------------------------------------------------------
package vrf_pkg;

  localparam int VLEN    = 128;             // bits per vector register
  localparam int NREG    = 32;              // architectural vector registers
  localparam int REG_AW  = $clog2(NREG);    // register address width
  localparam int VL_W    = 9;               // width of vl
  localparam int VTYPE_W = 7;               // width of vtype

  // vtype field layout: [2:0] vlmul, [5:3] vsew, [6] vta
  localparam int VLMUL_LSB = 0;
  localparam int VSEW_LSB  = 3;
  localparam int VTA_BIT   = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CFG   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_e;

  // vlmul and vsew must both select one of the four supported encodings.
  function automatic logic vtype_legal(input logic [VTYPE_W-1:0] vt);
    return (vt[VLMUL_LSB +: 3] <= 3'd3) && (vt[VSEW_LSB +: 3] <= 3'd3);
  endfunction

  // VLMAX = (elements of SEW=8 per register << vlmul) >> vsew.
  function automatic logic [VL_W-1:0] calc_vlmax(input logic [2:0] vlmul,
                                                 input logic [2:0] vsew);
    logic [VL_W-1:0] w_grp;
    w_grp = VL_W'(VLEN / 8) << vlmul;
    return w_grp >> vsew;
  endfunction

  // Registers touched by a vector op: ceil(vl / elements-per-register).
  // Elements per register is 16 >> vsew, a power of two, so the division
  // becomes a round-up add followed by a right shift of (4 - vsew).
  function automatic logic [VL_W-1:0] calc_nreg(input logic [VL_W-1:0] vl,
                                                input logic [2:0]      vsew);
    logic [VL_W:0] w_sum;
    w_sum = {1'b0, vl} + (VL_W+1)'(5'd16 >> vsew) - (VL_W+1)'(1);
    return VL_W'(w_sum >> (3'd4 - vsew));
  endfunction

endpackage

// File: rtl/vrf_seq_wpipe.sv
// -----------------------------------------------------------------------------
// vrf_seq_wpipe
// DEPTH-stage delay line carrying {valid, write address} from read-address
// issue to register-file write-back, matching the execute-unit latency.
//
// Ports
//   clk      in   clock
//   rst      in   asynchronous active-low reset (clears all valid bits)
//   i_clr    in   synchronous clear of all valid bits
//   i_valid  in   an element group is issued this cycle
//   i_addr   in   destination register of the issued group
//   o_valid  out  write-back this cycle (oldest stage)
//   o_addr   out  write-back address, 0 when o_valid is low
//   o_busy   out  a group is still in flight behind the oldest stage
// -----------------------------------------------------------------------------
module vrf_seq_wpipe #(
  parameter int DEPTH = 1,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic          o_busy
);

  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_addr [DEPTH];

  // NOTE: state is updated with non-blocking assignments so every stage
  // samples its predecessor's pre-edge value; blocking here would collapse
  // the whole line into a single stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
    end else if (i_clr) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_valid;
      for (int i = 1; i < DEPTH; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  // NOTE: the address stages are a plain data array with no reset; the
  // valid bits alone decide whether an address is ever observed.
  always_ff @(posedge clk) begin
    r_addr[0] <= i_addr;
    for (int i = 1; i < DEPTH; i++) r_addr[i] <= r_addr[i-1];
  end

  assign o_valid = r_vld[DEPTH-1];
  assign o_addr  = r_vld[DEPTH-1] ? r_addr[DEPTH-1] : '0;

  // NOTE: the default assignment ahead of the loop keeps this block purely
  // combinational; leaving it out would infer a latch.
  always_comb begin
    o_busy = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) o_busy = o_busy | r_vld[i];
  end

endmodule

// File: rtl/vrf_sequencer.sv
// -----------------------------------------------------------------------------
// vrf_sequencer
// Control sequencer in front of the vector register file. Accepts vsetvl and
// vector-op commands; vsetvl writes vl/vtype, vector ops walk the LMUL
// register group one register per cycle and schedule the delayed write-back.
// Register data never passes through this block.
//
// Build option
//   VRF_SEQ_ALIGN_CHECK_EN  when defined, a vector op whose vd/vs1/vs2 is not
//                           a multiple of LMUL completes at once with err.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   cmd_valid / cmd_ready        command handshake (ready only while idle)
//   cmd_op                       0 = vector op, 1 = vsetvl
//   cmd_vd, cmd_vs1, cmd_vs2     register group bases
//   cmd_avl, cmd_vtype           vsetvl operands
//   vl, vtype                    current register-file vl/vtype
//   rf_raA, rf_raB               read addresses (vs1+i, vs2+i)
//   rf_wa, rf_wen                write-back address / enable
//   rf_vl_in/_wen, rf_vtype_in/_wen  vl / vtype update
//   exe_valid                    read addresses form a valid element group
//   done, err                    completion pulse, illegal-command pulse
// -----------------------------------------------------------------------------
module vrf_sequencer
  import vrf_pkg::*;
#(
  parameter int AVL_W   = 16,
  parameter int EXE_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [REG_AW-1:0]  cmd_vd,
  input  logic [REG_AW-1:0]  cmd_vs1,
  input  logic [REG_AW-1:0]  cmd_vs2,
  input  logic [AVL_W-1:0]   cmd_avl,
  input  logic [VTYPE_W-1:0] cmd_vtype,
  input  logic [VL_W-1:0]    vl,
  input  logic [VTYPE_W-1:0] vtype,
  output logic [REG_AW-1:0]  rf_raA,
  output logic [REG_AW-1:0]  rf_raB,
  output logic [REG_AW-1:0]  rf_wa,
  output logic               rf_wen,
  output logic [VL_W-1:0]    rf_vl_in,
  output logic               rf_vl_wen,
  output logic [VTYPE_W-1:0] rf_vtype_in,
  output logic               rf_vtype_wen,
  output logic               exe_valid,
  output logic               done,
  output logic               err
);

  seq_state_e          r_state;
  logic                r_alive;      // low only until the first clock after reset
  logic [REG_AW-1:0]   r_vd, r_vs1, r_vs2;
  logic [VL_W-1:0]     r_nreg, r_idx;
  logic [VL_W-1:0]     r_cfg_vl;
  logic [VTYPE_W-1:0]  r_cfg_vtype;
  logic                r_cfg_err;
  logic                r_imm_done, r_imm_err;

  logic                w_accept;
  logic                w_cfg_legal;
  logic [VL_W-1:0]     w_vlmax, w_cfg_vl;
  logic                w_aligned, w_vop_legal;
  logic [VL_W-1:0]     w_vop_nreg;
  logic                w_issue;
  logic [REG_AW-1:0]   w_wr_addr;
  logic                w_pipe_busy;
  logic                w_unused_vta;

  assign w_accept = cmd_valid & cmd_ready;

  // vsetvl result, computed from the command itself at acceptance
  assign w_cfg_legal = vtype_legal(cmd_vtype);
  assign w_vlmax     = calc_vlmax(cmd_vtype[VLMUL_LSB +: 3], cmd_vtype[VSEW_LSB +: 3]);
  assign w_cfg_vl    = (cmd_avl < AVL_W'(w_vlmax)) ? cmd_avl[VL_W-1:0] : w_vlmax;

`ifdef VRF_SEQ_ALIGN_CHECK_EN
  logic [REG_AW-1:0] w_grp_mask;
  assign w_grp_mask = (REG_AW'(1) << vtype[VLMUL_LSB +: 3]) - REG_AW'(1);
  assign w_aligned  = ((cmd_vd | cmd_vs1 | cmd_vs2) & w_grp_mask) == '0;
`else
  assign w_aligned  = 1'b1;
`endif

  // Vector ops use vl/vtype as they stand at acceptance.
  assign w_vop_legal  = vtype_legal(vtype) & w_aligned;
  assign w_vop_nreg   = calc_nreg(vl, vtype[VSEW_LSB +: 3]);
  assign w_unused_vta = vtype[VTA_BIT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_alive     <= 1'b0;
      r_vd        <= '0;
      r_vs1       <= '0;
      r_vs2       <= '0;
      r_nreg      <= '0;
      r_idx       <= '0;
      r_cfg_vl    <= '0;
      r_cfg_vtype <= '0;
      r_cfg_err   <= 1'b0;
      r_imm_done  <= 1'b0;
      r_imm_err   <= 1'b0;
    end else begin
      r_alive    <= 1'b1;
      r_imm_done <= 1'b0;
      r_imm_err  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (cmd_op) begin
              r_cfg_vl    <= w_cfg_legal ? w_cfg_vl : '0;
              r_cfg_vtype <= w_cfg_legal ? cmd_vtype : '0;
              r_cfg_err   <= ~w_cfg_legal;
              r_state     <= ST_CFG;
            end else if (!w_vop_legal || (w_vop_nreg == '0)) begin
              // Nothing to issue: report completion next cycle, stay idle.
              r_imm_done <= 1'b1;
              r_imm_err  <= ~w_vop_legal;
            end else begin
              r_vd    <= cmd_vd;
              r_vs1   <= cmd_vs1;
              r_vs2   <= cmd_vs2;
              r_nreg  <= w_vop_nreg;
              r_idx   <= '0;
              r_state <= ST_RUN;
            end
          end
        end
        ST_CFG: r_state <= ST_IDLE;
        ST_RUN: begin
          r_idx <= r_idx + VL_W'(1);
          if (r_idx == r_nreg - VL_W'(1)) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Only the oldest stage may still hold a write: it retires now.
          if (!w_pipe_busy) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_issue   = (r_state == ST_RUN);
  assign w_wr_addr = r_vd + r_idx[REG_AW-1:0];

  vrf_seq_wpipe #(
    .DEPTH (EXE_LAT),
    .AW    (REG_AW)
  ) u_wpipe (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (r_state == ST_IDLE),
    .i_valid (w_issue),
    .i_addr  (w_wr_addr),
    .o_valid (rf_wen),
    .o_addr  (rf_wa),
    .o_busy  (w_pipe_busy)
  );

  assign cmd_ready    = r_alive & (r_state == ST_IDLE);
  assign exe_valid    = w_issue;
  assign rf_raA       = w_issue ? r_vs1 + r_idx[REG_AW-1:0] : '0;
  assign rf_raB       = w_issue ? r_vs2 + r_idx[REG_AW-1:0] : '0;
  assign rf_vl_wen    = (r_state == ST_CFG);
  assign rf_vtype_wen = (r_state == ST_CFG);
  assign rf_vl_in     = (r_state == ST_CFG) ? r_cfg_vl : '0;
  assign rf_vtype_in  = (r_state == ST_CFG) ? r_cfg_vtype : '0;
  assign done         = (r_state == ST_CFG) | ((r_state == ST_DRAIN) & ~w_pipe_busy) | r_imm_done;
  assign err          = ((r_state == ST_CFG) & r_cfg_err) | r_imm_err;

endmodule

// File: tb/tb_vrf_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vrf_sequencer
// Directed cases followed by random vsetvl / vector-op commands. The bench
// plays the register file: it holds vl/vtype itself and updates them from
// its own model of each vsetvl. For every command it builds the expected
// per-cycle output trace from the arithmetic rules and compares cycle by cycle.
// -----------------------------------------------------------------------------
module tb_vrf_sequencer;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_op;
  logic [4:0] cmd_vd, cmd_vs1, cmd_vs2;
  logic [15:0] cmd_avl;
  logic [6:0] cmd_vtype;
  logic [8:0] vl;
  logic [6:0] vtype;
  logic [4:0] rf_raA, rf_raB, rf_wa;
  logic       rf_wen, rf_vl_wen, rf_vtype_wen, exe_valid, done, err;
  logic [8:0] rf_vl_in;
  logic [6:0] rf_vtype_in;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vrf_sequencer #(.AVL_W(16), .EXE_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_vd(cmd_vd), .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2),
    .cmd_avl(cmd_avl), .cmd_vtype(cmd_vtype),
    .vl(vl), .vtype(vtype),
    .rf_raA(rf_raA), .rf_raB(rf_raB), .rf_wa(rf_wa), .rf_wen(rf_wen),
    .rf_vl_in(rf_vl_in), .rf_vl_wen(rf_vl_wen),
    .rf_vtype_in(rf_vtype_in), .rf_vtype_wen(rf_vtype_wen),
    .exe_valid(exe_valid), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output snapshot layout:
  // {ready, exe_valid, raA, raB, wen, wa, vl_wen, vl_in, vtype_wen, vtype_in, done, err}
  function automatic logic [63:0] mk(input logic rdy, input logic ev,
                                     input logic [4:0] ra, input logic [4:0] rb,
                                     input logic wen, input logic [4:0] wa,
                                     input logic vlw, input logic [8:0] vli,
                                     input logic vtw, input logic [6:0] vti,
                                     input logic dn, input logic er);
    return {26'd0, rdy, ev, ra, rb, wen, wa, vlw, vli, vtw, vti, dn, er};
  endfunction

  function automatic logic [63:0] idle_snap(input logic rdy);
    return mk(rdy, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Address/data fields only matter while their strobe is high.
  function automatic logic [63:0] obs();
    return mk(cmd_ready, exe_valid,
              exe_valid ? rf_raA : 5'd0, exe_valid ? rf_raB : 5'd0,
              rf_wen, rf_wen ? rf_wa : 5'd0,
              rf_vl_wen, rf_vl_wen ? rf_vl_in : 9'd0,
              rf_vtype_wen, rf_vtype_wen ? rf_vtype_in : 7'd0,
              done, err);
  endfunction

  function automatic logic [63:0] raw();
    return mk(cmd_ready, exe_valid, rf_raA, rf_raB, rf_wen, rf_wa,
              rf_vl_wen, rf_vl_in, rf_vtype_wen, rf_vtype_in, done, err);
  endfunction

  function automatic bit model_legal(input logic [6:0] vt);
    return (int'(vt[2:0]) <= 3) && (int'(vt[5:3]) <= 3);
  endfunction

  task automatic scramble_cmd();
    cmd_op    = 1'($urandom);
    cmd_vd    = 5'($urandom);
    cmd_vs1   = 5'($urandom);
    cmd_vs2   = 5'($urandom);
    cmd_avl   = 16'($urandom);
    cmd_vtype = 7'($urandom);
  endtask

  // Issue one command at the current negedge (cycle 0) and check cycles
  // 1..L plus the first idle cycle. Returns at the negedge of that idle
  // cycle, so the next command is accepted right after completion.
  task automatic run_cmd(input bit op, input logic [4:0] vd, input logic [4:0] vs1,
                         input logic [4:0] vs2, input int avl, input logic [6:0] vt,
                         input string name);
    logic [63:0] exp [0:15];
    bit          busy [0:15];
    int L, lmul, epr, n, vlmax, new_vl;
    bit bad;
    logic [6:0] new_vt;
    for (int c = 0; c < 16; c++) begin exp[c] = idle_snap(0); busy[c] = 1; end
    new_vl = 0; new_vt = 0;
    if (op) begin
      L = 1;
      bad = !model_legal(vt);
      if (!bad) begin
        vlmax  = (16 * (1 << int'(vt[2:0]))) / (1 << int'(vt[5:3]));
        new_vl = (avl < vlmax) ? avl : vlmax;
        new_vt = vt;
      end
      exp[1] = mk(0, 0, 0, 0, 0, 0, 1, 9'(new_vl), 1, new_vt, 1, bad);
    end else begin
      bad = !model_legal(vtype);
      lmul = 1 << int'(vtype[2:0]);
`ifdef VRF_SEQ_ALIGN_CHECK_EN
      if (!bad && ((int'(vd) % lmul) != 0 || (int'(vs1) % lmul) != 0 || (int'(vs2) % lmul) != 0))
        bad = 1;
`endif
      n = 0;
      if (!bad) begin
        epr = 16 / (1 << int'(vtype[5:3]));
        n = (int'(vl) + epr - 1) / epr;
      end
      if (n == 0) begin
        L = 1;
        exp[1] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, bad);
        busy[1] = 0;
      end else begin
        L = n + LAT;
        for (int c = 1; c <= L; c++) begin
          bit ev, wen;
          ev  = (c <= n);
          wen = (c > LAT);
          exp[c] = mk(0, ev, ev ? 5'(int'(vs1) + c - 1) : 5'd0,
                      ev ? 5'(int'(vs2) + c - 1) : 5'd0,
                      wen, wen ? 5'(int'(vd) + c - 1 - LAT) : 5'd0,
                      0, 0, 0, 0, (c == L), 0);
        end
      end
    end
    exp[L+1] = idle_snap(1);

    cmd_valid = 1; cmd_op = op; cmd_vd = vd; cmd_vs1 = vs1; cmd_vs2 = vs2;
    cmd_avl = 16'(avl); cmd_vtype = vt;
    @(posedge clk);
    #1;
    cmd_valid = 0;
    scramble_cmd();
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      check($sformatf("%s c%0d", name, k), obs(), exp[k]);
      if (op && k == 1) begin
        vl    = 9'(new_vl);
        vtype = new_vt;
      end
      // Commands presented while busy must be ignored.
      if (busy[k]) begin
        cmd_valid = 1'($urandom);
        scramble_cmd();
      end else begin
        cmd_valid = 0;
      end
    end
    @(negedge clk);
    cmd_valid = 0;
    check($sformatf("%s idle", name), obs(), exp[L+1]);
  endtask

  initial begin
    rst = 0; cmd_valid = 0;
    scramble_cmd();
    vl = 0; vtype = 0;
    #12;
    check("reset_outputs", raw(), 64'd0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("ready_after_reset", obs(), idle_snap(1));

    // vl = min(100, 64)
    run_cmd(1, 0, 0, 0, 100, 7'b0_000_010, "vsetvl_lmul4");
    // four registers: reads (16,24)..(19,27), writes 8..11
    run_cmd(0, 8, 16, 24, 0, 0, "vop_lmul4");
    // sew32 lmul8, vl=20 -> five registers
    run_cmd(1, 0, 0, 0, 20, 7'b0_010_011, "vsetvl_sew32");
    run_cmd(0, 8, 16, 24, 0, 0, "vop_n5");
    // illegal vsew -> vl=0, vtype=0, err
    run_cmd(1, 0, 0, 0, 50, 7'b0_101_000, "vsetvl_bad");
    run_cmd(0, 4, 5, 6, 0, 0, "vop_vl0");
    // lmul2: misaligned vd, then wrap past register 31
    run_cmd(1, 0, 0, 0, 32, 7'b0_000_001, "vsetvl_lmul2");
    run_cmd(0, 3, 0, 2, 0, 0, "vop_vd3");
    run_cmd(0, 31, 30, 29, 0, 0, "vop_wrap");
    run_cmd(1, 0, 0, 0, 7, 7'b1_011_000, "vsetvl_vta");

    // Reset in the middle of a four-register op.
    run_cmd(1, 0, 0, 0, 64, 7'b0_000_010, "vsetvl_rst");
    cmd_valid = 1; cmd_op = 0; cmd_vd = 0; cmd_vs1 = 4; cmd_vs2 = 12;
    @(posedge clk);
    #1 cmd_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre", obs(), mk(0, 1, 5, 13, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 0;
    #1 check("rst_now", raw(), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_hold%0d", k), raw(), 64'd0);
    end
    rst = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rst_after%0d", k), obs(), idle_snap(1));
    end

    // Random mix of commands.
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 9) < 4) begin
        logic [6:0] vt;
        int avl;
        if ($urandom_range(0, 4) == 0) vt = 7'($urandom);
        else vt = {1'($urandom), 1'b0, 2'($urandom), 1'b0, 2'($urandom)};
        avl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                          : int'($urandom_range(0, 140));
        run_cmd(1, 0, 0, 0, avl, vt, $sformatf("rnd%0d_vsetvl", it));
      end else begin
        logic [4:0] a, b, d, m;
        a = 5'($urandom); b = 5'($urandom); d = 5'($urandom);
        if ($urandom_range(0, 1) == 1 && vtype[2:0] <= 3'd3) begin
          m = 5'((1 << int'(vtype[2:0])) - 1);
          a = a & ~m; b = b & ~m; d = d & ~m;
        end
        run_cmd(0, d, a, b, 0, 0, $sformatf("rnd%0d_vop", it));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
